// File: rtl/gshare_bpu_if.sv
// gshare_bpu_if: lookup, update and status bundle between fetch/execute and the predictor
interface gshare_bpu_if #(
   parameter int PC_W = 32,
   parameter int IDX_W = 5,
   parameter int GH_W = 5
);
   logic flush;
   logic lookup_valid;
   logic [PC_W-1:0] lookup_pc;
   logic pred_valid;
   logic pred_taken;
   logic [IDX_W-1:0] pred_idx;
   logic upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic upd_taken;
   logic ready;
   logic [GH_W-1:0] ghr_out;
   modport master (
      output flush, lookup_valid, lookup_pc, upd_valid, upd_idx, upd_taken,
      input pred_valid, pred_taken, pred_idx, ready, ghr_out
   );
   modport slave (
      input flush, lookup_valid, lookup_pc, upd_valid, upd_idx, upd_taken,
      output pred_valid, pred_taken, pred_idx, ready, ghr_out
   );
endinterface

// File: rtl/gshare_bpu.sv
// gshare_bpu: gshare/bimodal direction predictor with init sweep and update-to-lookup forwarding
module gshare_bpu #(
   parameter int PC_W = 32,
   parameter int IDX_W = 5,
   parameter int CTR_W = 2,
   parameter int HIST_W = 5,
   parameter int INIT_CTR = (1 << (CTR_W - 1)) - 1
) (
   input logic clk,
   input logic rst,
   gshare_bpu_if.slave bus
);
   localparam int DEPTH = 1 << IDX_W;
   localparam int GH_W = HIST_W > 0 ? HIST_W : 1;
   typedef enum logic {INIT, RUN} state_t;
   state_t state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx, lu_idx;
   logic [GH_W-1:0] ghr;
   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [CTR_W-1:0] upd_old, upd_new, lu_ctr;
   logic lu, up, unused;
   assign unused = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0]};
   assign lu = bus.lookup_valid && state == RUN && !bus.flush;
   assign up = bus.upd_valid && state == RUN && !bus.flush;
   assign lu_idx = bus.lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
   assign upd_old = ctr_q[bus.upd_idx];
   assign bus.ready = state == RUN;
   assign bus.ghr_out = ghr;
   always_comb begin
      upd_new = bus.upd_taken ? (&upd_old ? upd_old : upd_old + 1'b1)
                              : (|upd_old ? upd_old - 1'b1 : upd_old);
      lu_ctr = (up && bus.upd_idx == lu_idx) ? upd_new : ctr_q[lu_idx];
      state_nx = bus.flush ? INIT : (state == INIT && ptr == '1) ? RUN : state;
      ptr_nx = bus.flush ? '0 : state == INIT ? ptr + 1'b1 : ptr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
         ptr <= '0;
         bus.pred_valid <= 1'b0;
         bus.pred_taken <= 1'b0;
         bus.pred_idx <= '0;
      end else begin
         state <= state_nx;
         ptr <= ptr_nx;
         bus.pred_valid <= lu;
         if (lu) begin
            bus.pred_taken <= lu_ctr[CTR_W-1];
            bus.pred_idx <= lu_idx;
         end
      end
   end
   // The flush edge writes nothing; the sweep restarts from entry 0 on the following edge.
   always_ff @(posedge clk) begin
      if (!bus.flush && state == INIT) ctr_q[ptr] <= CTR_W'(INIT_CTR);
      else if (up) ctr_q[bus.upd_idx] <= upd_new;
   end
   if (HIST_W > 0) begin : g_hist
      always_ff @(posedge clk or posedge rst) begin
         if (rst) ghr <= '0;
         else if (bus.flush) ghr <= '0;
         else if (up) ghr <= GH_W'({ghr, bus.upd_taken});
      end
   end else begin : g_bim
      assign ghr = '0;
   end
endmodule

// File: tb/tb_gshare_bpu.sv
// tb_gshare_bpu: scoreboard bench for a gshare instance (defaults) and a bimodal instance (HIST_W=0)
module tb_gshare_bpu;
   logic clk, rst;
   int n_cmp, n_bad;
   logic [5:0] qa[$];
   logic [5:0] qb[$];
   gshare_bpu_if #(.PC_W(32), .IDX_W(5), .GH_W(5)) ia ();
   gshare_bpu_if #(.PC_W(32), .IDX_W(5), .GH_W(1)) ib ();
   gshare_bpu u_a (.clk(clk), .rst(rst), .bus(ia));
   gshare_bpu #(.HIST_W(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Monitor: every presented prediction must match the oldest expected one.
   always @(negedge clk) begin
      if (ia.pred_valid === 1'b1) begin
         if (qa.size() == 0) chk("a_unexpected_pred", 1, 0);
         else chk("a_pred", {ia.pred_taken, ia.pred_idx}, qa.pop_front());
      end
      if (ib.pred_valid === 1'b1) begin
         if (qb.size() == 0) chk("b_unexpected_pred", 1, 0);
         else chk("b_pred", {ib.pred_taken, ib.pred_idx}, qb.pop_front());
      end
   end
   task automatic idle();
      ia.flush = 0; ia.lookup_valid = 0; ia.upd_valid = 0;
      ib.flush = 0; ib.lookup_valid = 0; ib.upd_valid = 0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic step();
      tick();
      idle();
   endtask
   task automatic drv_lu(input bit b, input logic [31:0] pc, input logic et, input logic [4:0] ei);
      if (b) begin
         ib.lookup_valid = 1; ib.lookup_pc = pc; qb.push_back({et, ei});
      end else begin
         ia.lookup_valid = 1; ia.lookup_pc = pc; qa.push_back({et, ei});
      end
   endtask
   task automatic drv_up(input bit b, input logic [4:0] idx, input logic t);
      if (b) begin
         ib.upd_valid = 1; ib.upd_idx = idx; ib.upd_taken = t;
      end else begin
         ia.upd_valid = 1; ia.upd_idx = idx; ia.upd_taken = t;
      end
   endtask
   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 0;
      idle();
      ia.lookup_pc = 0; ia.upd_idx = 0; ia.upd_taken = 0;
      ib.lookup_pc = 0; ib.upd_idx = 0; ib.upd_taken = 0;
      #3 rst = 1;
      #1;
      chk("rst_ready", ia.ready, 0);
      chk("rst_pred_valid", ia.pred_valid, 0);
      chk("rst_pred", {ia.pred_taken, ia.pred_idx}, 0);
      chk("rst_ghr", ia.ghr_out, 0);
      tick();
      rst = 0;
      for (int e = 1; e <= 32; e++) begin
         tick();
         chk("sweep_ready", ia.ready, e == 32);
      end
      chk("b_ready", ib.ready, 1);
      drv_lu(0, 32'h0, 0, 5'd0); step();
      // Bimodal saturation on idx 3: 01->10->11->11, then 10, 01.
      for (int i = 0; i < 3; i++) begin
         drv_up(1, 5'd3, 1); step();
         drv_lu(1, 32'h0C, 1, 5'd3); step();
      end
      drv_up(1, 5'd3, 0); step();
      drv_lu(1, 32'h0C, 1, 5'd3); step();
      drv_up(1, 5'd3, 0); step();
      drv_lu(1, 32'h0C, 0, 5'd3); step();
      chk("b_ghr_zero", ib.ghr_out, 0);
      // History T,T,N then gshare-indexed back-to-back lookups.
      drv_up(0, 5'd1, 1); step();
      drv_up(0, 5'd2, 1); step();
      drv_up(0, 5'd9, 0); step();
      chk("ghr_ttn", ia.ghr_out, 5'b00110);
      drv_lu(0, 32'h40, 0, 5'b10110); step();
      drv_lu(0, 32'h44, 0, 5'b10111); step();
      drv_lu(0, 32'h0, 1, 5'b00110); drv_up(0, 5'd6, 1); step();
      chk("ghr_after_fwd", ia.ghr_out, 5'b01101);
      drv_lu(1, 32'h1C, 1, 5'd7); drv_up(1, 5'd7, 1); step();
      drv_up(1, 5'd3, 1); step();
      drv_up(1, 5'd3, 1); step();
      drv_lu(1, 32'h0C, 1, 5'd3); step();
      // Flush wins over a same-cycle lookup and update.
      ia.flush = 1; ib.flush = 1;
      ia.lookup_valid = 1; ia.lookup_pc = 0;
      ia.upd_valid = 1; ia.upd_idx = 0; ia.upd_taken = 1;
      step();
      chk("flush_ready_a", ia.ready, 0);
      chk("flush_ready_b", ib.ready, 0);
      chk("flush_ghr", ia.ghr_out, 0);
      for (int e = 1; e <= 32; e++) begin
         if (e == 31) begin
            drv_up(0, 5'd0, 1);
            drv_up(1, 5'd3, 1);
            ib.lookup_valid = 1; ib.lookup_pc = 32'h0C;
         end
         step();
         chk("flush_sweep_ready", ia.ready, e == 32);
      end
      chk("dropped_upd_ghr", ia.ghr_out, 0);
      chk("b_ready_after_flush", ib.ready, 1);
      drv_lu(1, 32'h0C, 0, 5'd3); step();
      drv_lu(0, 32'h0C, 0, 5'd3); step();
      step();
      chk("held_pred_idx", ia.pred_idx, 3);
      ia.flush = 1; step();
      repeat (10) step();
      rst = 1;
      #1;
      chk("async_rst_idx", ia.pred_idx, 0);
      chk("async_rst_ready", ia.ready, 0);
      tick();
      rst = 0;
      for (int e = 1; e <= 32; e++) begin
         tick();
         chk("rst_mid_sweep_ready", ia.ready, e == 32);
      end
      step(); step();
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gshare_bpu.md
# gshare_bpu

Parametrised direction predictor for the fetch stage. It holds a table of 2^IDX_W saturating counters indexed by PC XOR global history (gshare), or by PC alone when HIST_W=0. Fetch issues lookups; the execute stage returns resolved outcomes through an update port. It generalises the 2-bit FSM/BHT pair to configurable depth, counter width and history length, and adds a reset/flush initialisation sweep and same-cycle read/write forwarding.

## Interface
- PC_W, 32: program-counter width.
- IDX_W, 5: table index width; DEPTH = 2^IDX_W entries.
- CTR_W, 2: counter width, minimum 1.
- HIST_W, 5: global history length, 0..IDX_W; 0 selects bimodal indexing.
- INIT_CTR, 2^(CTR_W-1)-1: counter value written by the sweep (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous re-initialisation: clears history and restarts the sweep.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  PC_W  PC of the fetched branch.
- pred_valid  out  1  prediction valid, one cycle after an accepted lookup.
- pred_taken  out  1  predicted direction (MSB of the counter).
- pred_idx  out  IDX_W  table index used; fetch carries it down the pipe to update.
- upd_valid  in  1  resolved branch this cycle.
- upd_idx  in  IDX_W  index returned from pred_idx.
- upd_taken  in  1  actual outcome.
- ready  out  1  table initialised; lookups and updates accepted only when 1.
- ghr_out  out  max(HIST_W,1)  current global history, for debug and checkpointing. Reads 0 when HIST_W=0.

## Operation
- Index: idx = lookup_pc[IDX_W+1:2] XOR {zeros, ghr}. Use the ghr value held before any same-cycle update.
- Counter update on an accepted upd_valid:
  - upd_taken=1: increment, saturating at 2^CTR_W-1.
  - upd_taken=0: decrement, saturating at 0.
  - The counter at upd_idx is the only entry written.
- History: each accepted update performs ghr <= {ghr[HIST_W-2:0], upd_taken}. For HIST_W=1 the history is just upd_taken. No history register exists when HIST_W=0.
- Sweep FSM states:
  - INIT: pointer walks 0..DEPTH-1, writing INIT_CTR to one entry per clock. ready=0. Lookups and updates are dropped.
  - RUN: ready=1. Lookups and updates are accepted.
- Transitions:
  - rst asserted → INIT, pointer 0, ghr 0.
  - INIT with pointer = DEPTH-1 → RUN on that edge.
  - flush=1 in any state → INIT, pointer 0, ghr 0. The flush edge performs no table write.
  - flush has priority over upd_valid and lookup_valid in the same cycle.
- Forwarding: if an accepted update and an accepted lookup hit the same index in one cycle, pred_taken reflects the post-update counter.
- Reset values: pred_valid=0, pred_taken=0, pred_idx=0, ready=0, ghr_out=0. Table contents are undefined until the sweep completes.

## Timing
- Lookup latency is 1 cycle. pred_valid, pred_taken and pred_idx are registered and valid for exactly one cycle per accepted lookup. Back-to-back lookups are supported every cycle.
- A lookup in a cycle with ready=0 yields pred_valid=0 on the next cycle.
- An update writes at the edge where upd_valid=1. A lookup of that index in the following cycle sees the new value.
- After rst deasserts, ready rises after exactly DEPTH rising edges: the edge that writes entry DEPTH-1 sets ready.
- After a flush edge, ready falls at that edge and rises DEPTH edges later.
- A flush or rst during INIT restarts the sweep from pointer 0.
- An rst assertion at any time clears all outputs immediately, without waiting for clk.

## Test plan
- Reset sweep (defaults): release rst → ready=0 for edges 1..31 and 1 at edge 32. A lookup at pc 0x0 then gives pred_taken=0 and pred_idx=0.
- Saturation, HIST_W=0: three updates of idx 3 taken → the counter goes 01→10→11→11, and a lookup at pc 0x0C predicts 1. Two not-taken updates then give 10 (predict 1) and 01 (predict 0).
- History, defaults:
  - Updates T, T, N → ghr_out = 5'b00110.
  - A lookup at pc 0x40 then gives pred_idx = 5'b10110.
- Forwarding, HIST_W=0: idx 7 holds 01. In the same cycle apply lookup pc 0x1C and update idx 7 taken → the next cycle shows pred_valid=1 and pred_taken=1.
- Flush mid-operation: after training idx 3 to 11, pulse flush → ready=0 and ghr_out=0 on the next cycle, ready returns 32 edges later, and a lookup at pc 0x0C predicts 0. An update issued while ready=0 leaves the table unchanged.
- Reset mid-sweep: assert rst at sweep edge 10 and release → ready rises 32 edges after release, not 22.
